// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam int DATA_W = 64;

    // Top-level sequencing: zero-fill the array, then serve requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Which requestor owns the single array port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } gnt_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's fetch/data ports and the
// memory responder.
//
// Handshake: a request transfers in the cycle where valid && ready are both
// high. The requestor holds valid and every request field stable until it
// sees ready; ready may depend combinationally on valid. Responses are
// one-cycle resp_valid pulses with no backpressure; the consumer samples them.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic              inst_req_valid;
    logic              inst_req_ready;
    logic [ADDR_W-1:0] inst_req_idx;
    logic              inst_resp_valid;
    logic [DATA_W-1:0] inst_resp_data;

    logic              data_req_valid;
    logic              data_req_ready;
    logic              data_req_wen;
    logic [ADDR_W-1:0] data_req_idx;
    logic [DATA_W-1:0] data_req_wdata;
    logic [DATA_W-1:0] data_req_wmask;
    logic              data_resp_valid;
    logic [DATA_W-1:0] data_resp_data;

    logic              init_busy;
    // Debug view of the sequencing FSM.
    state_t            state;

    modport master (
        output inst_req_valid, inst_req_idx,
        output data_req_valid, data_req_wen, data_req_idx,
        output data_req_wdata, data_req_wmask,
        input  inst_req_ready, inst_resp_valid, inst_resp_data,
        input  data_req_ready, data_resp_valid, data_resp_data,
        input  init_busy, state
    );

    modport slave (
        input  inst_req_valid, inst_req_idx,
        input  data_req_valid, data_req_wen, data_req_idx,
        input  data_req_wdata, data_req_wmask,
        output inst_req_ready, inst_resp_valid, inst_resp_data,
        output data_req_ready, data_resp_valid, data_resp_data,
        output init_busy, state
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter for the shared array port: data wins ties, but an
// instruction request waiting behind STARVE_MAX consecutive data grants is
// served next.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inst_valid,
    input  logic data_valid,
    input  logic in_run,
    output gnt_t grant
);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Grant selection, purely from the current valids and starvation state.
    always_comb begin
        grant = GNT_NONE;
        if (in_run) begin
            if (inst_valid && data_valid) begin
                grant = starved ? GNT_INST : GNT_DATA;
            end else if (data_valid) begin
                grant = GNT_DATA;
            end else if (inst_valid) begin
                grant = GNT_INST;
            end
        end
    end

    // Count data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant == GNT_INST || !inst_valid) begin
            starve_cnt <= '0;
        end else if (grant == GNT_DATA && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port word-addressed memory serving instruction fetch and data
// accesses. One request per cycle is accepted; its response appears exactly
// one cycle later. After reset the array can optionally be zero-filled.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_responder_if.slave        bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              in_run;
    gnt_t              grant;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] merged_wdata;

    // Readys must be low while reset is held, even if the FSM still says RUN.
    assign in_run = (state == RUN) && !reset;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arbiter (
        .clock      (clock),
        .reset      (reset),
        .inst_valid (bus.inst_req_valid),
        .data_valid (bus.data_req_valid),
        .in_run     (in_run),
        .grant      (grant)
    );

    assign bus.inst_req_ready = (grant == GNT_INST);
    assign bus.data_req_ready = (grant == GNT_DATA);
    assign bus.init_busy      = (state == INIT);
    assign bus.state          = state;

    assign merged_wdata = (mem[bus.data_req_idx] & ~bus.data_req_wmask)
                        | (bus.data_req_wdata & bus.data_req_wmask);

    // Single write port: zero-fill owns it in INIT, data writes own it in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.data_req_idx;
        mem_wdata = merged_wdata;
        if (state == INIT && !reset) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = '0;
        end else if (grant == GNT_DATA && bus.data_req_wen) begin
            mem_we = 1'b1;
        end
    end

    // Array storage; contents survive reset and are only cleared by INIT.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sequencing FSM: walk every index once in INIT, then stay in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= (INIT_ZERO != 0) ? INIT : RUN;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == {ADDR_W{1'b1}}) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Response registers: pulse valid for one cycle, keep data until replaced.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.inst_resp_valid <= 1'b0;
            bus.inst_resp_data  <= '0;
            bus.data_resp_valid <= 1'b0;
            bus.data_resp_data  <= '0;
        end else begin
            bus.inst_resp_valid <= (grant == GNT_INST);
            bus.data_resp_valid <= (grant == GNT_DATA);
            if (grant == GNT_INST) begin
                bus.inst_resp_data <= mem[bus.inst_req_idx];
            end
            if (grant == GNT_DATA) begin
                bus.data_resp_data <= bus.data_req_wen ? '0 : mem[bus.data_req_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a 16-word array and a starvation
// limit of 4.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW = 4;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    mem_responder_if #(.ADDR_W(AW)) bus ();

    mem_responder #(
        .ADDR_W     (AW),
        .STARVE_MAX (4),
        .INIT_ZERO  (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and global time limit.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Let combinational readys settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drv_idle();
        bus.inst_req_valid = 1'b0;
        bus.data_req_valid = 1'b0;
        bus.data_req_wen   = 1'b0;
    endtask

    task automatic drv_inst(input logic [AW-1:0] idx);
        bus.inst_req_valid = 1'b1;
        bus.inst_req_idx   = idx;
    endtask

    task automatic drv_read(input logic [AW-1:0] idx);
        bus.data_req_valid = 1'b1;
        bus.data_req_wen   = 1'b0;
        bus.data_req_idx   = idx;
        bus.data_req_wdata = '0;
        bus.data_req_wmask = '0;
    endtask

    task automatic drv_write(input logic [AW-1:0] idx, input logic [63:0] wdata,
                             input logic [63:0] wmask);
        bus.data_req_valid = 1'b1;
        bus.data_req_wen   = 1'b1;
        bus.data_req_idx   = idx;
        bus.data_req_wdata = wdata;
        bus.data_req_wmask = wmask;
    endtask

    // One directed write that must be accepted and acknowledged with data 0.
    task automatic do_write(input string tag, input logic [AW-1:0] idx,
                            input logic [63:0] wdata, input logic [63:0] wmask);
        drv_write(idx, wdata, wmask);
        settle();
        check({tag, "_ready"}, bus.data_req_ready, 1'b1);
        next();
        drv_idle();
        check({tag, "_ack_valid"}, bus.data_resp_valid, 1'b1);
        check({tag, "_ack_data"}, bus.data_resp_data, 64'h0);
    endtask

    logic [5:0] exp_dgnt;
    logic [5:0] exp_ignt;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.inst_req_idx   = '0;
        bus.data_req_idx   = '0;
        bus.data_req_wdata = '0;
        bus.data_req_wmask = '0;
        drv_idle();
        // Valids high during reset must not produce a grant.
        drv_inst(4'd1);
        drv_read(4'd1);
        next();
        next();
        settle();

        // Reset state.
        check("rst_inst_ready", bus.inst_req_ready, 1'b0);
        check("rst_data_ready", bus.data_req_ready, 1'b0);
        check("rst_inst_resp_valid", bus.inst_resp_valid, 1'b0);
        check("rst_data_resp_valid", bus.data_resp_valid, 1'b0);
        check("rst_inst_resp_data", bus.inst_resp_data, 64'h0);
        check("rst_data_resp_data", bus.data_resp_data, 64'h0);
        check("rst_init_busy", bus.init_busy, 1'b1);

        // Zero-fill: 16 cycles of busy with valids ignored.
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("init_busy", bus.init_busy, 1'b1);
            check("init_inst_ready", bus.inst_req_ready, 1'b0);
            check("init_data_ready", bus.data_req_ready, 1'b0);
            check("init_resp_valid", {bus.inst_resp_valid, bus.data_resp_valid}, 2'b00);
            next();
        end

        // First RUN cycle: read idx 5 returns the zero-filled word.
        drv_idle();
        drv_read(4'd5);
        settle();
        check("run_init_busy", bus.init_busy, 1'b0);
        check("run_first_ready", bus.data_req_ready, 1'b1);
        next();
        drv_idle();
        check("read5_valid", bus.data_resp_valid, 1'b1);
        check("read5_data", bus.data_resp_data, 64'h0);
        check("read5_inst_valid", bus.inst_resp_valid, 1'b0);
        next();
        check("read5_pulse_end", bus.data_resp_valid, 1'b0);

        // Masked write merges into the preloaded word.
        do_write("pre3", 4'd3, 64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF);
        do_write("mask3", 4'd3, 64'h1122334455667788, 64'h00000000FFFFFFFF);
        drv_read(4'd3);
        next();
        drv_idle();
        check("mask3_read", bus.data_resp_data, 64'hAAAAAAAA55667788);
        check("mask3_read_valid", bus.data_resp_valid, 1'b1);

        // Simultaneous requests: data first, then the held fetch.
        do_write("pre2", 4'd2, 64'h2222222222222222, 64'hFFFFFFFFFFFFFFFF);
        do_write("pre7", 4'd7, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF);
        drv_read(4'd2);
        drv_inst(4'd7);
        settle();
        check("tie_data_ready", bus.data_req_ready, 1'b1);
        check("tie_inst_ready", bus.inst_req_ready, 1'b0);
        next();
        check("tie_data_resp_valid", bus.data_resp_valid, 1'b1);
        check("tie_data_resp_data", bus.data_resp_data, 64'h2222222222222222);
        check("tie_inst_resp_early", bus.inst_resp_valid, 1'b0);
        bus.data_req_valid = 1'b0;
        settle();
        check("held_inst_ready", bus.inst_req_ready, 1'b1);
        next();
        drv_idle();
        check("held_inst_resp_valid", bus.inst_resp_valid, 1'b1);
        check("held_inst_resp_data", bus.inst_resp_data, 64'h0123456789ABCDEF);
        check("held_data_resp_valid", bus.data_resp_valid, 1'b0);
        next();
        check("inst_pulse_end", bus.inst_resp_valid, 1'b0);
        check("inst_data_hold", bus.inst_resp_data, 64'h0123456789ABCDEF);

        // Starvation guard: four data grants, then the fetch, then data again.
        exp_dgnt = 6'b101111;
        exp_ignt = 6'b010000;
        drv_read(4'd2);
        drv_inst(4'd7);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                check("starve_inst_resp", bus.inst_resp_valid, exp_ignt[i-1]);
            end
            settle();
            check("starve_data_ready", bus.data_req_ready, exp_dgnt[i]);
            check("starve_inst_ready", bus.inst_req_ready, exp_ignt[i]);
            next();
        end
        drv_idle();
        next();

        // Write then read the same index in the next cycle.
        do_write("w9", 4'd9, 64'hDEADBEEF00000001, 64'hFFFFFFFFFFFFFFFF);
        drv_read(4'd9);
        settle();
        check("r9_ready", bus.data_req_ready, 1'b1);
        next();
        drv_idle();
        check("r9_data", bus.data_resp_data, 64'hDEADBEEF00000001);
        next();

        // Reset from RUN, then a second reset pulse in cycle 7 of init.
        drv_read(4'd9);
        drv_inst(4'd7);
        reset = 1'b1;
        settle();
        check("run_rst_data_ready", bus.data_req_ready, 1'b0);
        check("run_rst_inst_ready", bus.inst_req_ready, 1'b0);
        next();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            settle();
            check("pre_pulse_busy", bus.init_busy, 1'b1);
            check("pre_pulse_resp", {bus.inst_resp_valid, bus.data_resp_valid}, 2'b00);
            next();
        end
        reset = 1'b1;
        next();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("reinit_busy", bus.init_busy, 1'b1);
            check("reinit_readys", {bus.inst_req_ready, bus.data_req_ready}, 2'b00);
            check("reinit_resp", {bus.inst_resp_valid, bus.data_resp_valid}, 2'b00);
            next();
        end
        settle();
        check("reinit_done", bus.init_busy, 1'b0);
        check("reinit_data_ready", bus.data_req_ready, 1'b1);
        next();
        drv_idle();
        check("reinit_r9_valid", bus.data_resp_valid, 1'b1);
        check("reinit_r9_zero", bus.data_resp_data, 64'h0);
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port, word-addressed memory responder that serves the core's instruction-fetch and data-access requests over valid/ready handshakes. Each accepted request gets a response exactly one cycle later. Both requestors share one port, so a fixed-priority arbiter with a starvation guard decides who is served, and a losing requestor sees `ready` low and holds its request. It replaces the simulation RAM helper as the synthesizable memory target of the pipeline; `~inst_req_ready` and `~data_req_ready` feed the hazard unit as stall sources.

## Interface
- `ADDR_W`, 12: word-index width; depth is 2^ADDR_W 64-bit words.
- `STARVE_MAX`, 4: maximum consecutive data grants while an instruction request is waiting.
- `INIT_ZERO`, 1: 1 zero-fills the array after reset; 0 skips init and starts in RUN.
- `clock`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `inst_req_valid`  in  1  fetch request present.
- `inst_req_ready`  out  1  fetch request accepted this cycle.
- `inst_req_idx`  in  ADDR_W  fetch word index.
- `inst_resp_valid`  out  1  fetch data valid; one-cycle pulse.
- `inst_resp_data`  out  64  fetched word.
- `data_req_valid`  in  1  data request present.
- `data_req_ready`  out  1  data request accepted this cycle.
- `data_req_wen`  in  1  1 = write, 0 = read.
- `data_req_idx`  in  ADDR_W  data word index.
- `data_req_wdata`  in  64  write data, already lane-aligned.
- `data_req_wmask`  in  64  bit-level write mask.
- `data_resp_valid`  out  1  read data valid or write acknowledge; one-cycle pulse.
- `data_resp_data`  out  64  read word; 0 for write acks.
- `init_busy`  out  1  zero-fill in progress.

## Operation
- States: INIT and RUN.
  - Reset enters INIT if INIT_ZERO=1, otherwise RUN.
  - INIT writes 0 to index `init_cnt`, then increments. `init_cnt` resets to 0.
  - INIT moves to RUN after index 2^ADDR_W−1 is written.
  - In INIT, both readys are 0 and `init_busy` is 1.
- Arbitration in RUN, combinational from the valids:
  - Only one valid: that requestor is granted.
  - Both valid: data is granted, unless `starve_cnt == STARVE_MAX`; then inst is granted.
  - `ready` = grant. A request handshakes when `valid && ready`.
- `starve_cnt`:
  - Increments when data is granted while `inst_req_valid` is 1.
  - Clears on any inst grant, or when `inst_req_valid` is 0.
  - Saturates at STARVE_MAX.
- Read: the array word at idx is registered into the resp data.
- Write: `mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask)`.
- Requestors hold valid and all request fields stable until ready. The block does not latch a losing request.
- Response ports have no backpressure; the consumer must sample the pulse.
- Out-of-range indices cannot occur, since idx is exactly ADDR_W wide.

## Timing
- Reset values:
  - readys 0 during reset.
  - `inst_resp_valid` = 0, `data_resp_valid` = 0.
  - `inst_resp_data` = 0, `data_resp_data` = 0.
  - `init_busy` = INIT_ZERO.
  - `starve_cnt` = 0.
- Latency: handshake in cycle t gives `resp_valid` = 1 with data in cycle t+1, held only for that cycle. Resp data regs hold their last value afterwards.
- Back-to-back requests: one grant per cycle, so throughput is 1 request per cycle total across both ports.
- Write in cycle t followed by a read of the same idx in cycle t+1 returns the written data. The write is committed at edge t.
- Init length: 2^ADDR_W cycles; first ready can be 1 in cycle 2^ADDR_W after reset deasserts.
- Reset asserted mid-init: `init_cnt` returns to 0 and the full init restarts.
- Reset asserted in RUN: responses for requests accepted in the previous cycle are dropped (resp_valid forced 0). Array contents are not restored except by the following INIT.
- In INIT, valids are ignored and no responses are generated.

## Structure
- Package `mem_pkg`:
  - State enum {INIT, RUN}.
  - Constant `DATA_W` = 64.
  - Grant encoding {GNT_NONE, GNT_INST, GNT_DATA}.
- Sub-module `mem_arbiter`: inputs are the two valids and `in_run`; it holds `starve_cnt` and outputs the grant.
- The top level holds the array, the init FSM and counter, the masked write, and the response registers.

## Test plan
- Reset-mode init with ADDR_W=4 → readys low and `init_busy` = 1 for 16 cycles; a read of idx 5 then returns 0 one cycle after the handshake.
- Preload idx 3 = 0xAAAAAAAAAAAAAAAA, then write wdata 0x1122334455667788 with wmask 0x00000000FFFFFFFF → ack `data_resp_data` = 0; a subsequent read returns 0xAAAAAAAA55667788.
- Both valids in the same cycle, with data read idx 2 and inst read idx 7 → data granted, `inst_req_ready` = 0; inst granted the next cycle, and `inst_resp_valid` pulses one cycle after that.
- `data_req_valid` held high continuously together with `inst_req_valid` (STARVE_MAX=4) → data granted 4 cycles, inst granted on the 5th, then data resumes.
- Reset pulse at cycle 7 of init (ADDR_W=4) → `init_busy` stays 1 for a further 16 cycles after reset deasserts; no resp_valid at any point.
- Write idx 9 = 0xDEADBEEF00000001 with full mask, then read idx 9 in the next cycle → `data_resp_data` = 0xDEADBEEF00000001.
